load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access and writeback stage of the RV32I core. It sits between execute and the register file. It takes a load/store request (address, store data, funct3, destination register), runs a single-outstanding request/acknowledge transaction on the data-memory bus, and aligns and extends load data. It then presents `RegWrite`/`rd`/`WD3` to the register file for exactly one cycle, and asserts `busy` so upstream stalls while the access is in flight.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte address width of `addr`/`mem_addr`.

Ports:
- Clocking: one clock `clk`; reset `rst` is asynchronous and active-high.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request valid; sampled only when `busy`=0.
- `is_store` in 1: 1 = store, 0 = load.
- `funct3` in 3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `addr` in ADDR_WIDTH: byte address.
- `store_data` in 32: rs2 value.
- `rd_in` in 5: load destination register.
- `busy` out 1: access in progress; upstream holds its stage.
- `done` out 1: one-cycle completion pulse.
- `misalign` out 1: misaligned-access flag.
- `mem_req` out 1: bus request.
- `mem_we` out 1: bus write enable.
- `mem_addr` out ADDR_WIDTH: word-aligned address, bits [1:0] = 00.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_be` out 4: byte enables.
- `mem_ack` in 1: bus acknowledge.
- `mem_rdata` in 32: read word, valid in the cycle `mem_ack`=1.
- `RegWrite` out 1: register-file write enable.
- `rd` out 5: register-file destination.
- `WD3` out 32: register-file write data.

## Operation
- FSM states: IDLE, REQ, WB. `busy` = (state != IDLE).
- IDLE:
  - On `start`=1, latch `is_store`, `funct3`, `addr`, `store_data`, `rd_in`.
  - Legal and aligned request: go to REQ.
  - Illegal funct3 (load 011/110/111; store other than 000/001/010): go to WB with no bus access.
  - While `busy`=1, `start` is ignored.
- REQ:
  - `mem_req`=1. `mem_we`, `mem_addr`, `mem_wdata` and `mem_be` are held stable until the cycle `mem_ack`=1.
  - On `mem_ack`, capture the aligned load result and go to WB.
  - No timeout.
- WB: `done`=1 for one cycle, then return to IDLE. `mem_ack` is ignored outside REQ.
- Register write:
  - `RegWrite`=1 only in WB, for a legal non-misaligned load with `rd`!=0.
  - Writes to x0 are suppressed here because the register file does not guard x0.
  - `RegWrite` is 0 for stores.
- Byte enables:
  - SB: `mem_be` = 0001 << addr[1:0]; `mem_wdata` = store_data[7:0] replicated ×4.
  - SH: `mem_be` = 0011 if addr[1]=0, else 1100; `mem_wdata` = store_data[15:0] replicated ×2.
  - SW: `mem_be` = 1111; `mem_wdata` = store_data.
  - Loads: `mem_be` = 1111, `mem_we` = 0.
- Load extraction and extension:
  - Byte = mem_rdata[8·addr[1:0] +: 8]; halfword = mem_rdata[16·addr[1] +: 16].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
- Outputs hold 0 when not in their active state: `mem_req`, `mem_we`, `mem_be`, `RegWrite`, `done`, `misalign`.

## Timing
- Reset values: state = IDLE, and every output = 0 (including `mem_addr`, `mem_wdata`, `rd`, `WD3`).
- Reset is asynchronous. Asserting `rst` mid-transaction drops `mem_req` immediately and abandons the access: no `done`, no `RegWrite`.
- Cycle numbering: `start` is sampled at edge E0, and `mem_req` rises after E0.
  - If `mem_ack`=1 is sampled at edge Ek, WB occupies the cycle after Ek.
  - The register file commits `WD3` at edge Ek+1.
  - Minimum latency, `start` to `done`: 2 cycles (ack in the first REQ cycle).
- Illegal or trapped requests: WB occurs in the cycle after E0, so `done` follows 1 cycle after `start`.
- `busy` is high from the cycle after E0 through the WB cycle inclusive. A new `start` is accepted in the cycle after WB.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- Defined:
  - Misaligned accesses are LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]!=00.
  - These issue no bus request. The FSM goes IDLE→WB, with `misalign`=1 and `done`=1 in that WB cycle and `RegWrite`=0.
- Undefined:
  - The `misalign` port exists but is tied to 0.
  - Misaligned halfwords ignore addr[0]; misaligned words ignore addr[1:0]. The access proceeds normally.

## Test plan
- LW: addr=0x104, `mem_rdata`=0xDEADBEEF, ack on the first REQ cycle → `mem_addr`=0x104, `mem_be`=1111; 2 cycles later `RegWrite`=1, `WD3`=0xDEADBEEF, `rd`=5, `done`=1.
- LB vs LBU: addr=0x203, `mem_rdata`=0x80112233 → LB gives `WD3`=0xFFFFFF80, LBU gives `WD3`=0x00000080. Both have `mem_addr`=0x200.
- SH: addr=0x12, store_data=0x0000ABCD, ack delayed 3 cycles → `mem_be`=1100, `mem_wdata`=0xABCDABCD, held stable across all 3 wait cycles; `done` with `RegWrite`=0.
- LW to x0: ack received → `done`=1 but `RegWrite`=0. Additionally, `start` pulsed while `busy`=1 → ignored, and no second `mem_req` is issued.
- Reset: `rst` asserted in REQ → `mem_req` drops the same cycle; all outputs 0, state IDLE; a later `mem_ack` produces nothing.
- LW addr=0x102:
  - With `LSU_MISALIGN_TRAP_EN` → no `mem_req`; `misalign`=1 and `done`=1 one cycle after `start`.
  - Without it → `mem_addr`=0x100 and a normal load.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I memory-access/writeback stage: single-outstanding req/ack data bus, load alignment and extension.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned halfword/word accesses instead of ignoring low bits).
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           store_data,
  input  logic [4:0]            rd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  misalign,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic                  RegWrite,
  output logic [4:0]            rd,
  output logic [31:0]           WD3
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WB   = 2'b10
  } state_t;

  function automatic logic legal_op(input logic st, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~st;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic m;
    case (f3[1:0])
      2'b01:   m = lo[0];
      2'b10:   m = (lo != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction
`endif

  function automatic logic [3:0] byte_enable(input logic st, input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    if (!st) begin
      be = 4'b1111;
    end else begin
      case (f3[1:0])
        2'b00:   be = 4'b0001 << lo;
        2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{data[7:0]}};
      2'b01:   w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'b00:   b = rdata[7:0];
      2'b01:   b = rdata[15:8];
      2'b10:   b = rdata[23:16];
      2'b11:   b = rdata[31:24];
      default: b = 8'h00;
    endcase
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  state_t                  state_r, state_nxt_s;
  logic                    is_store_r;
  logic [2:0]              funct3_r;
  logic [1:0]              addr_lo_r;
  logic                    latch_s, legal_s, trap_s;
  logic                    mem_req_r, mem_req_nxt_s;
  logic                    mem_we_r, mem_we_nxt_s;
  logic [ADDR_WIDTH-1:0]   mem_addr_r, mem_addr_nxt_s;
  logic [31:0]             mem_wdata_r, mem_wdata_nxt_s;
  logic [3:0]              mem_be_r, mem_be_nxt_s;
  logic                    done_r, done_nxt_s;
  logic                    misalign_r, misalign_nxt_s;
  logic                    reg_write_r, reg_write_nxt_s;
  logic [4:0]              rd_r, rd_nxt_s;
  logic [31:0]             wd3_r, wd3_nxt_s;

  assign legal_s = legal_op(is_store, funct3);
`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_s  = legal_s & misaligned(funct3, addr[1:0]);
`else
  assign trap_s  = 1'b0;
`endif

  // Next-state and next-output decode; bus outputs are computed one cycle ahead so they leave flops.
  always_comb begin
    state_nxt_s     = state_r;
    latch_s         = 1'b0;
    mem_req_nxt_s   = 1'b0;
    mem_we_nxt_s    = 1'b0;
    mem_be_nxt_s    = 4'b0000;
    mem_addr_nxt_s  = mem_addr_r;
    mem_wdata_nxt_s = mem_wdata_r;
    done_nxt_s      = 1'b0;
    misalign_nxt_s  = 1'b0;
    reg_write_nxt_s = 1'b0;
    rd_nxt_s        = rd_r;
    wd3_nxt_s       = wd3_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          latch_s  = 1'b1;
          rd_nxt_s = rd_in;
          if (!legal_s || trap_s) begin
            state_nxt_s    = ST_WB;
            done_nxt_s     = 1'b1;
            misalign_nxt_s = trap_s;
          end else begin
            state_nxt_s     = ST_REQ;
            mem_req_nxt_s   = 1'b1;
            mem_we_nxt_s    = is_store;
            mem_addr_nxt_s  = {addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_nxt_s = lane_wdata(funct3, store_data);
            mem_be_nxt_s    = byte_enable(is_store, funct3, addr[1:0]);
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_nxt_s     = ST_WB;
          done_nxt_s      = 1'b1;
          // The register file does not guard x0, so suppress that write here.
          reg_write_nxt_s = ~is_store_r & (rd_r != 5'd0);
          if (!is_store_r) begin
            wd3_nxt_s = load_extract(funct3_r, addr_lo_r, mem_rdata);
          end else begin
            wd3_nxt_s = wd3_r;
          end
        end else begin
          state_nxt_s   = ST_REQ;
          mem_req_nxt_s = 1'b1;
          mem_we_nxt_s  = mem_we_r;
          mem_be_nxt_s  = mem_be_r;
        end
      end
      ST_WB:   state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, request context and registered outputs; async reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      is_store_r  <= 1'b0;
      funct3_r    <= 3'b000;
      addr_lo_r   <= 2'b00;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 32'h0000_0000;
      mem_be_r    <= 4'b0000;
      done_r      <= 1'b0;
      misalign_r  <= 1'b0;
      reg_write_r <= 1'b0;
      rd_r        <= 5'd0;
      wd3_r       <= 32'h0000_0000;
    end else begin
      state_r     <= state_nxt_s;
      if (latch_s) begin
        is_store_r <= is_store;
        funct3_r   <= funct3;
        addr_lo_r  <= addr[1:0];
      end
      mem_req_r   <= mem_req_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      mem_be_r    <= mem_be_nxt_s;
      done_r      <= done_nxt_s;
      misalign_r  <= misalign_nxt_s;
      reg_write_r <= reg_write_nxt_s;
      rd_r        <= rd_nxt_s;
      wd3_r       <= wd3_nxt_s;
    end
  end

  assign busy      = (state_r != ST_IDLE);
  assign done      = done_r;
  assign misalign  = misalign_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_be    = mem_be_r;
  assign RegWrite  = reg_write_r;
  assign rd        = rd_r;
  assign WD3       = wd3_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; expected values are hand-computed constants.
// Honours LSU_MISALIGN_TRAP_EN the same way as the design.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic [4:0]  rd_in = 5'd0;
  logic        busy, done, misalign, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] WD3;

  int total_cnt = 0;
  int bad_cnt   = 0;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .rd_in(rd_in), .busy(busy), .done(done),
    .misalign(misalign), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .RegWrite(RegWrite), .rd(rd), .WD3(WD3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] r);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd; rd_in = r;
    step();
    start = 1'b0;
  endtask

  task automatic ack(input logic [31:0] data);
    mem_ack = 1'b1; mem_rdata = data;
    step();
    mem_ack = 1'b0;
  endtask

  initial begin
    // reset state
    step(); step();
    chk("rst_busy", busy, 0);     chk("rst_req", mem_req, 0);  chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0); chk("rst_be", mem_be, 0);  chk("rst_wd3", WD3, 0);
    chk("rst_rd", rd, 0);         chk("rst_done", done, 0);    chk("rst_rw", RegWrite, 0);
    rst = 1'b0;
    step();

    // LW 0x104 -> x5
    issue(1'b0, 3'b010, 32'h104, 32'h0, 5'd5);
    chk("lw_req", mem_req, 1); chk("lw_we", mem_we, 0); chk("lw_addr", mem_addr, 32'h104);
    chk("lw_be", mem_be, 4'b1111); chk("lw_busy", busy, 1); chk("lw_done0", done, 0);
    ack(32'hDEADBEEF);
    chk("lw_done", done, 1); chk("lw_rw", RegWrite, 1); chk("lw_wd3", WD3, 32'hDEADBEEF);
    chk("lw_rd", rd, 5); chk("lw_req_off", mem_req, 0);
    step();
    chk("lw_idle", busy, 0); chk("lw_done_off", done, 0); chk("lw_rw_off", RegWrite, 0);

    // LB / LBU at 0x203
    issue(1'b0, 3'b000, 32'h203, 32'h0, 5'd7);
    chk("lb_addr", mem_addr, 32'h200);
    ack(32'h80112233);
    chk("lb_wd3", WD3, 32'hFFFFFF80); chk("lb_rw", RegWrite, 1);
    step();
    issue(1'b0, 3'b100, 32'h203, 32'h0, 5'd7);
    chk("lbu_addr", mem_addr, 32'h200);
    ack(32'h80112233);
    chk("lbu_wd3", WD3, 32'h00000080);
    step();

    // LH / LHU upper half
    issue(1'b0, 3'b001, 32'h302, 32'h0, 5'd9);
    ack(32'h80011234);
    chk("lh_wd3", WD3, 32'hFFFF8001);
    step();
    issue(1'b0, 3'b101, 32'h300, 32'h0, 5'd9);
    ack(32'h80011234);
    chk("lhu_wd3", WD3, 32'h00001234);
    step();

    // SH 0x12, ack after 3 wait cycles
    issue(1'b1, 3'b001, 32'h12, 32'h0000ABCD, 5'd3);
    for (int i = 0; i < 3; i++) begin
      chk("sh_req", mem_req, 1); chk("sh_we", mem_we, 1); chk("sh_addr", mem_addr, 32'h10);
      chk("sh_be", mem_be, 4'b1100); chk("sh_wdata", mem_wdata, 32'hABCDABCD);
      step();
    end
    chk("sh_req_last", mem_req, 1);
    ack(32'h0);
    chk("sh_done", done, 1); chk("sh_rw", RegWrite, 0); chk("sh_we_off", mem_we, 0);
    chk("sh_be_off", mem_be, 0);
    step();

    // SB 0x1 and SW
    issue(1'b1, 3'b000, 32'h41, 32'h1234565A, 5'd0);
    chk("sb_be", mem_be, 4'b0010); chk("sb_wdata", mem_wdata, 32'h5A5A5A5A);
    chk("sb_addr", mem_addr, 32'h40);
    ack(32'h0);
    step();
    issue(1'b1, 3'b010, 32'h48, 32'hCAFEF00D, 5'd0);
    chk("sw_be", mem_be, 4'b1111); chk("sw_wdata", mem_wdata, 32'hCAFEF00D);
    ack(32'h0);
    step();

    // LW to x0 with a start pulse while busy
    issue(1'b0, 3'b010, 32'h500, 32'h0, 5'd0);
    start = 1'b1; addr = 32'h900; funct3 = 3'b010; is_store = 1'b0;
    step();
    start = 1'b0;
    chk("x0_addr_hold", mem_addr, 32'h500); chk("x0_req", mem_req, 1);
    ack(32'h55AA55AA);
    chk("x0_done", done, 1); chk("x0_rw", RegWrite, 0); chk("x0_req_off", mem_req, 0);
    step();
    chk("x0_idle", busy, 0); chk("x0_no_req", mem_req, 0);
    step();
    chk("x0_no_req2", mem_req, 0); chk("x0_no_done", done, 0);

    // Illegal funct3: load 011 and store 100 finish without bus access
    issue(1'b0, 3'b011, 32'h600, 32'h0, 5'd4);
    chk("ill_done", done, 1); chk("ill_req", mem_req, 0); chk("ill_rw", RegWrite, 0);
    chk("ill_busy", busy, 1); chk("ill_mis", misalign, 0);
    step();
    chk("ill_idle", busy, 0);
    issue(1'b1, 3'b100, 32'h600, 32'h0, 5'd4);
    chk("ill_st_done", done, 1); chk("ill_st_req", mem_req, 0);
    step();

    // Async reset in REQ
    issue(1'b0, 3'b010, 32'h700, 32'h0, 5'd6);
    chk("rr_req", mem_req, 1);
    rst = 1'b1;
    #1;
    chk("rr_req_drop", mem_req, 0); chk("rr_busy", busy, 0); chk("rr_addr", mem_addr, 0);
    chk("rr_rd", rd, 0); chk("rr_be", mem_be, 0);
    #2;
    rst = 1'b0;
    ack(32'h12345678);
    chk("rr_done", done, 0); chk("rr_rw", RegWrite, 0); chk("rr_wd3", WD3, 0);
    step();
    chk("rr_idle", busy, 0);

    // LW at 0x102
    issue(1'b0, 3'b010, 32'h102, 32'h0, 5'd8);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_req", mem_req, 0); chk("mis_flag", misalign, 1); chk("mis_done", done, 1);
    chk("mis_rw", RegWrite, 0);
    step();
    chk("mis_flag_off", misalign, 0); chk("mis_idle", busy, 0);
`else
    chk("mis_req", mem_req, 1); chk("mis_addr", mem_addr, 32'h100); chk("mis_flag", misalign, 0);
    ack(32'h11223344);
    chk("mis_wd3", WD3, 32'h11223344); chk("mis_rw", RegWrite, 1); chk("mis_done", done, 1);
    step();
    chk("mis_idle", busy, 0);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
